multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences one instruction over 3-5+ cycles and drives every 2:1 mux select (1-bit) and 3:1 mux select (2-bit, values 0..2 only) plus all datapath write enables.
- Sits between the instruction register opcode field and the mux/register/memory instances.
- Waits on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of the state register and state debug port.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  6  IR[31:26]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if branch condition is true (gated internally)
- pc_en  output  1  pc_write | (pc_write_cond & cond)
- pc_src  output  2  0=ALU result, 1=ALUOut reg, 2=jump target
- iord  output  1  memory address mux: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0=PC, 1=reg A
- alu_src_b  output  2  0=reg B, 1=const 4, 2=sign-ext imm
- imm_shift  output  1  shift sign-ext imm left by 2 on alu_src_b=2
- alu_op  output  2  0=add, 1=sub, 2=funct-decoded
- illegal_op  output  1  one-cycle pulse on an unknown opcode
- state  output  STATE_W  current state (debug)

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register. Any output not listed for a state is 0.
- While reset=1, all outputs are forced to 0. The state register loads FETCH on the clock edge while reset=1.
- Deasserting reset mid-instruction restarts cleanly at FETCH; no partial writes.
- States and outputs:
  - FETCH(0): mem_read, ir_write, alu_src_b=1, pc_write, alu_op=0. ir_write and pc_write are gated by mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): alu_src_b=2, imm_shift=1, alu_op=0.
    - lw/sw (100011/101011) -> MEMADR
    - R-type (000000) -> EXEC
    - beq (000100) -> BRANCH
    - addi (001000) -> ADDIEX
    - j (000010) -> JUMP
    - any other opcode -> FETCH, with illegal_op=1 for this cycle
  - MEMADR(2): alu_src_a=1, alu_src_b=2, alu_op=0. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): mem_read, iord=1. Holds until mem_ready=1, then -> MEMWB.
  - MEMWB(4): reg_write, mem_to_reg=1, reg_dst=0. -> FETCH.
  - MEMWR(5): mem_write, iord=1. Holds until mem_ready=1, then -> FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=0, alu_op=2. -> ALUWB.
  - ALUWB(7): reg_write, reg_dst=1, mem_to_reg=0. -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond, pc_src=1. cond=zero. -> FETCH.
  - ADDIEX(9): alu_src_a=1, alu_src_b=2, alu_op=0. -> ADDIWB.
  - ADDIWB(10): reg_write, reg_dst=0, mem_to_reg=0. -> FETCH.
  - JUMP(11): pc_write, pc_src=2. -> FETCH.
- Unused state encodings (12-15) -> FETCH next cycle, with all outputs 0.
- CPI: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle adds 1.
- opcode is sampled only in DECODE and MEMADR. The IR is stable because ir_write=0 outside FETCH.
- The 2-bit selects never take the value 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN
- Defined: opcode 000101 (bne) in DECODE -> BRANCH. A registered flag captured in DECODE selects cond=~zero; beq uses cond=zero. Only state BRANCH is shared.
- Undefined: 000101 is illegal (illegal_op pulse, -> FETCH). The flag logic is not present.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum/localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - ALUOP_ADD/SUB/FUNCT
  - select constants PCSRC_*, SRCB_*
- One sub-module is natural: multicycle_ctrl_decode, a pure combinational state-to-outputs decoder. The top keeps the state register and next-state logic.

Test Plan:
- Reset high 2 cycles, then low, mem_ready=1 -> state=0; outputs all 0 during reset; next cycle mem_read=1, ir_write=1, pc_write=1, alu_src_b=1.
- lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; MEMWB has reg_write=1, mem_to_reg=1; 5 cycles total.
- sw with mem_ready low 3 cycles in MEMWR -> mem_write=1, iord=1 held for 4 cycles; return to FETCH only after mem_ready=1; reg_write never 1.
- beq with zero=1 -> pc_en=1, pc_src=1 in BRANCH. Same with zero=0 -> pc_en=0. With MULTICYCLE_CTRL_BNE_EN, bne inverts both results.
- Opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE; next state FETCH; no reg_write/mem_write at any point.
- Reset asserted in MEMRD -> next state FETCH; no MEMWB reg_write occurs.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM.
// Optional bne support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
package mips_ctrl_pkg;

  localparam int unsigned STATE_BITS = 4;
  localparam int unsigned OP_W       = 6;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_shift;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode that DECODE dispatches somewhere other than FETCH.
  function automatic logic opcode_known(input logic [OP_W-1:0] op);
    logic known;
    known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MULTICYCLE_CTRL_BNE_EN
    known = known || (op == OP_BNE);
`endif
    return known;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control decoder for the multicycle MIPS FSM.
// Illegal-opcode detection follows MULTICYCLE_CTRL_BNE_EN via the package.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t                state_i,
  input  logic                  mem_ready_i,
  input  logic [OP_W-1:0]       opcode_i,
  output ctrl_t                 ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        // IR load and PC+4 only commit once memory delivers the word
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.imm_shift  = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = ~opcode_known(opcode_i);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REGB;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state
// logic and reset gating. Define MULTICYCLE_CTRL_BNE_EN to add bne support.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_shift,
  output logic [1:0]         alu_op,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_g;
  logic   cond;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  // Branch sense is latched in DECODE so BRANCH can be shared by beq and bne
  logic bne_q, bne_d;

  always_comb begin
    bne_d = bne_q;
    if (state_q == S_DECODE) bne_d = (opcode == OP_BNE);
  end

  always_ff @(posedge clk) begin
    if (reset) bne_q <= 1'b0;
    else       bne_q <= bne_d;
  end

  assign cond = bne_q ? ~zero : zero;
`else
  assign cond = zero;
`endif

  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .opcode_i    (opcode),
    .ctrl_o      (ctrl)
  );

  // Reset forces every output low regardless of the current state
  assign ctrl_g = reset ? '0 : ctrl;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign pc_en         = ctrl_g.pc_write | (ctrl_g.pc_write_cond & cond);
  assign pc_src        = ctrl_g.pc_src;
  assign iord          = ctrl_g.iord;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign reg_dst       = ctrl_g.reg_dst;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign imm_shift     = ctrl_g.imm_shift;
  assign alu_op        = ctrl_g.alu_op;
  assign illegal_op    = ctrl_g.illegal_op;
  assign state         = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// reset corner case, and randomized run against an instruction-level model.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = LW;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, imm_shift, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_shift(imm_shift), .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic [3:0] st;
    logic [5:0] key;  // {mem_read, ir_write, pc_en, reg_write, mem_write, illegal_op}
  } vec_t;

  vec_t tbl[$];
  int   path_q[$];

  function automatic vec_t mk(input logic r, input logic [5:0] o, input logic zz,
                              input logic m, input logic [3:0] s, input logic [5:0] k);
    vec_t v;
    v.rst = r; v.op = o; v.z = zz; v.mr = m; v.st = s; v.key = k;
    return v;
  endfunction

  function automatic logic [22:0] act_vec();
    return {state, pc_write, pc_write_cond, pc_en, pc_src, iord, mem_read, mem_write,
            ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_shift,
            alu_op, illegal_op};
  endfunction

  function automatic logic [9:0] act_key();
    return {state, mem_read, ir_write, pc_en, reg_write, mem_write, illegal_op};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) ||
           (op == JMP) || (BNE_EN && op == BNE);
  endfunction

  // Expected outputs for a given step of an instruction, from the state table
  function automatic logic [22:0] model_out(input int st, input logic mr,
                                            input logic [5:0] op, input logic z);
    logic pw, pwc, pe, io, mrd, mwr, irw, rdst, m2r, rw, sa, ims, ill, c;
    logic [1:0] ps, sb, aop;
    pw = 0; pwc = 0; io = 0; mrd = 0; mwr = 0; irw = 0; rdst = 0; m2r = 0;
    rw = 0; sa = 0; ims = 0; ill = 0; ps = 0; sb = 0; aop = 0;
    c = (BNE_EN && op == BNE) ? ~z : z;
    case (st)
      0:  begin mrd = 1; irw = mr; pw = mr; sb = 2'd1; end
      1:  begin sb = 2'd2; ims = 1; ill = !legal(op); end
      2, 9: begin sa = 1; sb = 2'd2; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin sa = 1; aop = 2'd2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin sa = 1; aop = 2'd1; pwc = 1; ps = 2'd1; end
      10: rw = 1;
      11: begin pw = 1; ps = 2'd2; end
      default: ;
    endcase
    pe = pw | (pwc & c);
    return {4'(st), pw, pwc, pe, ps, io, mrd, mwr, irw, rdst, m2r, rw, sa, sb, ims, aop, ill};
  endfunction

  // Sequence of states one instruction visits when memory never stalls
  task automatic build_path(input logic [5:0] op);
    path_q.delete();
    path_q.push_back(0);
    path_q.push_back(1);
    case (op)
      LW:   begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
      SW:   begin path_q.push_back(2); path_q.push_back(5); end
      RT:   begin path_q.push_back(6); path_q.push_back(7); end
      BEQ:  path_q.push_back(8);
      BNE:  if (BNE_EN) path_q.push_back(8);
      ADDI: begin path_q.push_back(9); path_q.push_back(10); end
      JMP:  path_q.push_back(11);
      default: ;
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 8))
      0: return LW;   1: return SW;   2: return RT;
      3: return BEQ;  4: return BNE;  5: return ADDI;
      6: return JMP;  7: return BAD;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic zz, input logic m);
    @(negedge clk);
    reset = r; opcode = o; zero = zz; mem_ready = m;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [5:0] cur_op;
    logic       r, m, zz;
    logic [22:0] exp;

    // Directed per-cycle vectors: {rst, op, zero, mem_ready, state, key}
    tbl.push_back(mk(1, LW, 0, 1, 0, 6'b000000));
    tbl.push_back(mk(1, LW, 0, 1, 0, 6'b000000));
    tbl.push_back(mk(0, LW, 0, 1, 0, 6'b111000));
    tbl.push_back(mk(0, LW, 0, 1, 1, 6'b000000));
    tbl.push_back(mk(0, LW, 0, 1, 2, 6'b000000));
    tbl.push_back(mk(0, LW, 0, 1, 3, 6'b100000));
    tbl.push_back(mk(0, LW, 0, 1, 4, 6'b000100));
    tbl.push_back(mk(0, SW, 0, 0, 0, 6'b100000));
    tbl.push_back(mk(0, SW, 0, 1, 0, 6'b111000));
    tbl.push_back(mk(0, SW, 0, 1, 1, 6'b000000));
    tbl.push_back(mk(0, SW, 0, 1, 2, 6'b000000));
    tbl.push_back(mk(0, SW, 0, 0, 5, 6'b000010));
    tbl.push_back(mk(0, SW, 0, 0, 5, 6'b000010));
    tbl.push_back(mk(0, SW, 0, 0, 5, 6'b000010));
    tbl.push_back(mk(0, SW, 0, 1, 5, 6'b000010));
    tbl.push_back(mk(0, BEQ, 1, 1, 0, 6'b111000));
    tbl.push_back(mk(0, BEQ, 1, 1, 1, 6'b000000));
    tbl.push_back(mk(0, BEQ, 1, 1, 8, 6'b001000));
    tbl.push_back(mk(0, BEQ, 0, 1, 0, 6'b111000));
    tbl.push_back(mk(0, BEQ, 0, 1, 1, 6'b000000));
    tbl.push_back(mk(0, BEQ, 0, 1, 8, 6'b000000));
    tbl.push_back(mk(0, BAD, 0, 1, 0, 6'b111000));
    tbl.push_back(mk(0, BAD, 0, 1, 1, 6'b000001));
    tbl.push_back(mk(0, RT, 0, 1, 0, 6'b111000));
    tbl.push_back(mk(0, RT, 0, 1, 1, 6'b000000));
    tbl.push_back(mk(0, RT, 0, 1, 6, 6'b000000));
    tbl.push_back(mk(0, RT, 0, 1, 7, 6'b000100));
    tbl.push_back(mk(0, ADDI, 0, 1, 0, 6'b111000));
    tbl.push_back(mk(0, ADDI, 0, 1, 1, 6'b000000));
    tbl.push_back(mk(0, ADDI, 0, 1, 9, 6'b000000));
    tbl.push_back(mk(0, ADDI, 0, 1, 10, 6'b000100));
    tbl.push_back(mk(0, JMP, 0, 1, 0, 6'b111000));
    tbl.push_back(mk(0, JMP, 0, 1, 1, 6'b000000));
    tbl.push_back(mk(0, JMP, 0, 1, 11, 6'b001000));
    tbl.push_back(mk(0, BNE, 1, 1, 0, 6'b111000));
    if (BNE_EN) begin
      tbl.push_back(mk(0, BNE, 1, 1, 1, 6'b000000));
      tbl.push_back(mk(0, BNE, 1, 1, 8, 6'b000000));
    end else begin
      tbl.push_back(mk(0, BNE, 1, 1, 1, 6'b000001));
      tbl.push_back(mk(0, BNE, 1, 1, 0, 6'b111000));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr);
      check($sformatf("vec%0d", i), 32'(act_key()), 32'({tbl[i].st, tbl[i].key}));
      if (tbl[i].rst)
        check($sformatf("vec%0d_rst_all", i), 32'(act_vec()), 32'd0);
    end

    // Reset while lw waits in MEMRD: restart at FETCH, MEMWB never happens
    step(1, LW, 0, 1); check("rd_rst0", 32'(act_vec()), 32'd0);
    step(0, LW, 0, 1); check("rd_fetch", 32'(act_key()), 32'({4'd0, 6'b111000}));
    step(0, LW, 0, 1); check("rd_decode", 32'(act_key()), 32'({4'd1, 6'b000000}));
    step(0, LW, 0, 1); check("rd_memadr", 32'(act_key()), 32'({4'd2, 6'b000000}));
    step(0, LW, 0, 0); check("rd_memrd", 32'(act_key()), 32'({4'd3, 6'b100000}));
    step(1, LW, 0, 1); check("rd_rst_mid", 32'(act_vec()), 32'd0);
    step(0, LW, 0, 1); check("rd_restart", 32'(act_key()), 32'({4'd0, 6'b111000}));
    step(0, LW, 0, 1); check("rd_nowb", 32'(act_key()), 32'({4'd1, 6'b000000}));

    // Randomized run against the instruction-level model
    step(1, LW, 0, 1); check("rnd_rst", 32'(act_vec()), 32'd0);
    path_q.delete();
    cur_op = LW;
    for (int c = 0; c < 2000; c++) begin
      if (path_q.size() == 0) begin
        cur_op = pick_op();
        build_path(cur_op);
      end
      r  = ($urandom_range(0, 49) == 0);
      m  = ($urandom_range(0, 3) != 0);
      zz = 1'($urandom_range(0, 1));
      step(r, cur_op, zz, m);
      exp = r ? 23'd0 : model_out(path_q[0], m, cur_op, zz);
      check($sformatf("rnd%0d", c), 32'(act_vec()), 32'(exp));
      if (r) path_q.delete();
      else if (!((path_q[0] == 0 || path_q[0] == 3 || path_q[0] == 5) && !m))
        void'(path_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
